tx_serializer: RTL and testbench
================================

// Module: tx_serializer
// PURPOSE
//  Receiving end of the controller's sample-transmit interface (tx_o/tx_stb_o/tx_rdy_i).
//  - Accepts one TX_WIDTH-bit word per handshake.
//  - Splits the word into bytes, least-significant byte first.
//  - Skips bytes whose channel group is disabled.
//  - Presents the bytes one at a time on a valid/ready byte stream to the UART transmitter.
// PARAMETERS
//  TX_WIDTH  32  word width in bits; must be a multiple of 8 (NB = TX_WIDTH/8 byte lanes)
// PORTS
//  clk_i       in   1         clock; all logic on rising edge
//  rst_i       in   1         reset, synchronous, active-high
//  tx_stb_i    in   1         word strobe from ctrl; word accepted when tx_stb_i & tx_rdy_o
//  tx_i        in   TX_WIDTH  word to send; sampled on accept
//  tx_rdy_o    out  1         ready for a new word (drives ctrl tx_rdy_i)
//  grp_en_i    in   NB        byte-lane enable (1 = send lane k); sampled on accept
//  byte_o      out  8         current byte to the UART
//  byte_vld_o  out  1         byte_o valid; transfer when byte_vld_o & byte_rdy_i
//  byte_rdy_i  in   1         UART ready to take a byte
//  busy_o      out  1         a word is being serialized
//  ovr_o       out  1         one-cycle pulse: tx_stb_i seen while tx_rdy_o=0 (word dropped)
// BEHAVIOUR
//  - Reset values: tx_rdy_o=1, byte_vld_o=0, byte_o=0, busy_o=0, ovr_o=0. Reset empties any buffer.
//  - Reset mid-word: the remaining bytes are discarded and the next cycle is IDLE.
//  - FSM states: IDLE, SEND.
//  - IDLE: tx_rdy_o=1.
//    - On accept with grp_en_i != 0: latch the word and mask, go to SEND.
//    - On accept with grp_en_i == 0: word consumed, nothing emitted, stay in IDLE, tx_rdy_o stays 1.
//  - SEND: tx_rdy_o=0, busy_o=1, byte_vld_o=1.
//    - byte_o = tx_i[8k+7:8k], where k is the lowest set bit of the remaining mask.
//  - Latency: accept in cycle N -> byte_vld_o=1 with the first enabled byte in cycle N+1.
//  - On transfer, the bit for lane k is cleared in the remaining mask.
//    - Next enabled byte appears in the following cycle; byte_vld_o stays high, no bubble.
//  - byte_o and byte_vld_o must be stable while byte_vld_o=1 and byte_rdy_i=0.
//  - Transfer of the last enabled byte in cycle M: SEND -> IDLE; byte_vld_o=0 and tx_rdy_o=1 in cycle M+1.
//  - ovr_o fires in the cycle after tx_stb_i=1 with tx_rdy_o=0. The dropped word has no other effect.
//  - byte_rdy_i high while byte_vld_o=0 has no effect.
// CONFIGURATION
//  TXSER_BUF_EN defined:
//  - Adds a one-word holding buffer (data + mask).
//  - tx_rdy_o = !buffer_full, also during SEND, so one word is accepted while another is serialized.
//  - When the last byte transfers and the buffer is full, the buffered word starts in the next cycle.
//    byte_vld_o stays 1 (no bubble) and the buffer frees.
//  - Accept and last-byte transfer in the same cycle with the buffer empty: the word is loaded
//    directly into the shifter and sent from the next cycle.
//  - A buffered word with mask 0 is dropped silently when popped.
//  TXSER_BUF_EN undefined:
//  - No buffer; tx_rdy_o = (state == IDLE), exactly as above.
// TESTING
//  1. Reset: hold rst_i=1 for 2 cycles mid-SEND -> next cycle byte_vld_o=0, tx_rdy_o=1, busy_o=0.
//  2. Word 0xDDCCBBAA, grp_en=4'b1111, byte_rdy_i=1 -> bytes AA,BB,CC,DD on 4 consecutive cycles
//     starting at N+1; tx_rdy_o=1 at N+5.
//  3. Word 0x44332211, grp_en=4'b1010 -> bytes 22 then 44 only; grp_en=4'b0000 -> no byte,
//     tx_rdy_o never drops.
//  4. Backpressure: byte_rdy_i=0 for 5 cycles on the first byte -> byte_o=AA held, byte_vld_o=1
//     throughout; sequence resumes unchanged.
//  5. Overrun (no buffer): tx_stb_i pulse during SEND -> ovr_o=1 for exactly one cycle; the active
//     word completes intact.
//  6. With TXSER_BUF_EN: two words back-to-back -> second accepted during SEND; 8 bytes stream
//     with byte_vld_o continuously 1; ovr_o stays 0.

Source files
------------

// File: rtl/tx_serializer.sv
// tx_serializer: word-to-byte serializer between ctrl and UART.
// Optional one-word holding buffer when TXSER_BUF_EN is defined.
//
// Purpose: accepts one TX_WIDTH-bit word per tx_stb_i/tx_rdy_o
// handshake and emits its enabled byte lanes LSB-first on a
// valid/ready byte stream.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   tx_stb_i   word strobe; accept = tx_stb_i & tx_rdy_o
//   tx_i       word, sampled on accept
//   tx_rdy_o   ready for a new word
//   grp_en_i   byte-lane enables, sampled on accept
//   byte_o     current byte
//   byte_vld_o byte_o valid
//   byte_rdy_i UART ready; transfer = byte_vld_o & byte_rdy_i
//   busy_o     a word is being serialized
//   ovr_o      one-cycle pulse: strobe seen while not ready
module tx_serializer #(
  parameter int TX_WIDTH = 32,
  localparam int NB = TX_WIDTH / 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tx_stb_i,
  input  logic [TX_WIDTH-1:0] tx_i,
  output logic                tx_rdy_o,
  input  logic [NB-1:0]       grp_en_i,
  output logic [7:0]          byte_o,
  output logic                byte_vld_o,
  input  logic                byte_rdy_i,
  output logic                busy_o,
  output logic                ovr_o
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [NB-1:0] ONE = NB'(1);

  state_t              state_q, state_d;
  logic [TX_WIDTH-1:0] data_q, data_d;
  logic [NB-1:0]       mask_q, mask_d;
  logic [7:0]          byte_q, byte_d;
  logic                ovr_q, ovr_d;

`ifdef TXSER_BUF_EN
  logic [TX_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [NB-1:0]       buf_mask_q, buf_mask_d;
  logic                buf_full_q, buf_full_d;
`endif

  logic          xfer;
  logic          last;
  logic          accept;
  logic          need;
  logic [NB-1:0] mask_rem;

  // Byte of the lowest enabled lane in m.
  function automatic logic [7:0] pick(
    input logic [TX_WIDTH-1:0] d,
    input logic [NB-1:0]       m
  );
    logic [7:0] r;
    r = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (m[k]) r = d[8*k +: 8];
    end
    return r;
  endfunction

`ifdef TXSER_BUF_EN
  assign tx_rdy_o = ~buf_full_q;
`else
  assign tx_rdy_o = (state_q == IDLE);
`endif

  assign byte_vld_o = (state_q == SEND);
  assign busy_o     = (state_q == SEND);
  assign byte_o     = byte_q;
  assign ovr_o      = ovr_q;

  assign xfer     = byte_vld_o & byte_rdy_i;
  // Clears the lowest set bit: the lane just transferred.
  assign mask_rem = mask_q & (mask_q - ONE);
  assign last     = xfer & (mask_rem == '0);
  assign accept   = tx_stb_i & tx_rdy_o;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    ovr_d   = tx_stb_i & ~tx_rdy_o;
    need    = 1'b1;
`ifdef TXSER_BUF_EN
    buf_data_d = buf_data_q;
    buf_mask_d = buf_mask_q;
    buf_full_d = buf_full_q;
`endif

    unique case (state_q)
      IDLE:    need = 1'b1;
      SEND:    need = last;
      default: need = 1'b1;
    endcase

    if (xfer) mask_d = mask_rem;

    if (need) begin
      // Shifter is free next cycle: refill from the
      // buffer first, else straight from the port.
`ifdef TXSER_BUF_EN
      if (buf_full_q) begin
        data_d     = buf_data_q;
        mask_d     = buf_mask_q;
        buf_full_d = 1'b0;
      end else
`endif
      if (accept) begin
        data_d = tx_i;
        mask_d = grp_en_i;
      end else begin
        mask_d = '0;
      end
      // An all-disabled word is consumed with no output.
      state_d = (mask_d != '0) ? SEND : IDLE;
    end
`ifdef TXSER_BUF_EN
    else if (accept) begin
      buf_data_d = tx_i;
      buf_mask_d = grp_en_i;
      buf_full_d = 1'b1;
    end
`endif

    byte_d = (state_d == SEND) ? pick(data_d, mask_d) : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      byte_q  <= '0;
      ovr_q   <= 1'b0;
`ifdef TXSER_BUF_EN
      buf_data_q <= '0;
      buf_mask_q <= '0;
      buf_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      byte_q  <= byte_d;
      ovr_q   <= ovr_d;
`ifdef TXSER_BUF_EN
      buf_data_q <= buf_data_d;
      buf_mask_q <= buf_mask_d;
      buf_full_q <= buf_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: self-checking bench for tx_serializer
// (default build, no holding buffer).
module tb_tx_serializer;

  localparam int W  = 32;
  localparam int NB = W / 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          tx_stb_i;
  logic [W-1:0]  tx_i;
  logic          tx_rdy_o;
  logic [NB-1:0] grp_en_i;
  logic [7:0]    byte_o;
  logic          byte_vld_o;
  logic          byte_rdy_i;
  logic          busy_o;
  logic          ovr_o;

  tx_serializer #(.TX_WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tx_stb_i   (tx_stb_i),
    .tx_i       (tx_i),
    .tx_rdy_o   (tx_rdy_o),
    .grp_en_i   (grp_en_i),
    .byte_o     (byte_o),
    .byte_vld_o (byte_vld_o),
    .byte_rdy_i (byte_rdy_i),
    .busy_o     (busy_o),
    .ovr_o      (ovr_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]  word;
    logic [NB-1:0] en;
    logic [31:0]   bytes;
    int            n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic       ovr_exp;
    logic       rdy_m;
    logic [7:0] exp_b[3];

    vecs[0] = '{32'hDDCCBBAA, 4'b1111, 32'hDDCCBBAA, 4};
    vecs[1] = '{32'h44332211, 4'b1010, 32'h00004422, 2};
    vecs[2] = '{32'h44332211, 4'b0000, 32'h00000000, 0};
    vecs[3] = '{32'h12345678, 4'b1000, 32'h00000012, 1};
    vecs[4] = '{32'h12345678, 4'b0001, 32'h00000078, 1};
    vecs[5] = '{32'hA1B2C3D4, 4'b0110, 32'h0000B2C3, 2};
    vecs[6] = '{32'h5A6B7C8D, 4'b0101, 32'h00006B8D, 2};

    rst_i      = 1'b1;
    tx_stb_i   = 1'b0;
    tx_i       = '0;
    grp_en_i   = '0;
    byte_rdy_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rdy",  tx_rdy_o,   1);
    chk("rst_vld",  byte_vld_o, 0);
    chk("rst_byte", byte_o,     0);
    chk("rst_busy", busy_o,     0);
    chk("rst_ovr",  ovr_o,      0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Table-driven single words, full-speed UART.
    for (int i = 0; i < 7; i++) begin
      tx_stb_i   = 1'b1;
      tx_i       = vecs[i].word;
      grp_en_i   = vecs[i].en;
      byte_rdy_i = 1'b1;
      @(negedge clk_i);
      tx_stb_i = 1'b0;
      tx_i     = $urandom;
      grp_en_i = 4'($urandom);
      for (int j = 0; j < vecs[i].n; j++) begin
        chk($sformatf("v%0d_vld%0d", i, j), byte_vld_o, 1);
        chk($sformatf("v%0d_byte%0d", i, j), byte_o,
            32'(vecs[i].bytes[8*j +: 8]));
        chk($sformatf("v%0d_rdy%0d", i, j), tx_rdy_o, 0);
        @(negedge clk_i);
      end
      chk($sformatf("v%0d_end_vld", i), byte_vld_o, 0);
      chk($sformatf("v%0d_end_rdy", i), tx_rdy_o, 1);
      chk($sformatf("v%0d_end_busy", i), busy_o, 0);
    end

    // Reset mid-word discards the rest.
    tx_stb_i   = 1'b1;
    tx_i       = 32'hDDCCBBAA;
    grp_en_i   = 4'hF;
    byte_rdy_i = 1'b1;
    @(negedge clk_i);
    tx_stb_i = 1'b0;
    chk("mrst_first", byte_o, 32'hAA);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("mrst_vld",  byte_vld_o, 0);
    chk("mrst_rdy",  tx_rdy_o,   1);
    chk("mrst_busy", busy_o,     0);
    chk("mrst_byte", byte_o,     0);
    @(negedge clk_i);
    chk("mrst_idle", byte_vld_o, 0);

    // Backpressure on the first byte.
    tx_stb_i   = 1'b1;
    tx_i       = 32'hDDCCBBAA;
    grp_en_i   = 4'hF;
    byte_rdy_i = 1'b0;
    @(negedge clk_i);
    tx_stb_i = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_vld%0d", j), byte_vld_o, 1);
      chk($sformatf("bp_byte%0d", j), byte_o, 32'hAA);
      @(negedge clk_i);
    end
    chk("bp_hold", byte_o, 32'hAA);
    byte_rdy_i = 1'b1;
    exp_b = '{8'hBB, 8'hCC, 8'hDD};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);
      chk($sformatf("bp_res%0d", j), byte_o, 32'(exp_b[j]));
      chk($sformatf("bp_resv%0d", j), byte_vld_o, 1);
    end
    @(negedge clk_i);
    chk("bp_end_rdy", tx_rdy_o, 1);

    // Overrun: strobe during SEND.
    tx_stb_i = 1'b1;
    tx_i     = 32'h87654321;
    grp_en_i = 4'hF;
    @(negedge clk_i);
    chk("ov_b0", byte_o, 32'h21);
    chk("ov_o0", ovr_o, 0);
    tx_i = 32'hFFFFFFFF;
    @(negedge clk_i);
    tx_stb_i = 1'b0;
    chk("ov_b1", byte_o, 32'h43);
    chk("ov_pulse", ovr_o, 1);
    @(negedge clk_i);
    chk("ov_b2", byte_o, 32'h65);
    chk("ov_o2", ovr_o, 0);
    @(negedge clk_i);
    chk("ov_b3", byte_o, 32'h87);
    chk("ov_o3", ovr_o, 0);
    @(negedge clk_i);
    chk("ov_end_vld", byte_vld_o, 0);
    chk("ov_end_rdy", tx_rdy_o, 1);
    chk("ov_end_ovr", ovr_o, 0);

    // Random traffic vs a byte-queue model.
    ovr_exp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_vld",  byte_vld_o, 32'(q.size() != 0));
      chk("rnd_rdy",  tx_rdy_o,   32'(q.size() == 0));
      chk("rnd_busy", busy_o,     32'(q.size() != 0));
      chk("rnd_ovr",  ovr_o,      32'(ovr_exp));
      if (q.size() != 0) chk("rnd_byte", byte_o, 32'(q[0]));
      tx_stb_i   = ($urandom_range(0, 3) == 0);
      tx_i       = $urandom;
      grp_en_i   = 4'($urandom);
      byte_rdy_i = ($urandom_range(0, 3) != 0);
      rdy_m      = (q.size() == 0);
      if (!rdy_m && byte_rdy_i) begin
        void'(q.pop_front());
      end else if (rdy_m && tx_stb_i) begin
        for (int k = 0; k < NB; k++)
          if (grp_en_i[k]) q.push_back(tx_i[8*k +: 8]);
      end
      ovr_exp = tx_stb_i && !rdy_m;
      @(negedge clk_i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
